// File: rtl/model_fnn_output_vector.sv
`default_nettype none
// ============================================================================
// Module   : model_fnn_output_vector
// Purpose  : FNN output stage. Buffers the hidden vector h (L words), then
//            streams the row-major weights U (Y x L) and emits
//            y[i] = sat((sum_l U[i][l] * h[l]) >>> FRACTION_SIZE).
//            Signed fixed point with saturation to the data width.
// Revision : 1.0 - initial release
// ============================================================================
module model_fnn_output_vector #(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32,
  parameter int L_MAX         = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_L_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_Y_IN,
  input  logic                    H_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    H_IN,
  input  logic                    U_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    U_IN,
  output logic                    Y_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    Y_OUT
);

  localparam int PROD_W = 2 * DATA_SIZE;
  // Headroom so that L_MAX full-scale products can be summed without wrapping.
  localparam int ACC_W  = PROD_W + $clog2(L_MAX) + 1;
  localparam int AW     = (L_MAX > 1) ? $clog2(L_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_H = 2'd1,
    MAC    = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CONTROL_SIZE-1:0] size_l, size_y, idx_l, idx_i;
  logic [CONTROL_SIZE-1:0] size_l_clamped;
  logic [DATA_SIZE-1:0]    h_buf [L_MAX];
  logic [DATA_SIZE-1:0]    h_rd;

  logic signed [PROD_W-1:0] u_ext, h_ext, prod;
  logic signed [ACC_W-1:0]  acc, acc_sum, acc_shift;
  logic [ACC_W-DATA_SIZE:0] hi_bits;
  logic [DATA_SIZE-1:0]     y_sat;

  logic size_zero, h_last, u_last, row_last;

  // Size decode, element-count compares and the MAC/saturation datapath.
  always_comb begin
    size_l_clamped = (SIZE_L_IN > CONTROL_SIZE'(L_MAX)) ? CONTROL_SIZE'(L_MAX) : SIZE_L_IN;
    size_zero      = (size_l_clamped == '0) || (SIZE_Y_IN == '0);
    h_last         = H_IN_ENABLE && (idx_l == size_l - CONTROL_SIZE'(1));
    u_last         = U_IN_ENABLE && (idx_l == size_l - CONTROL_SIZE'(1));
    row_last       = (idx_i == size_y - CONTROL_SIZE'(1));

    h_rd      = h_buf[idx_l[AW-1:0]];
    u_ext     = {{DATA_SIZE{U_IN[DATA_SIZE-1]}}, U_IN};
    h_ext     = {{DATA_SIZE{h_rd[DATA_SIZE-1]}}, h_rd};
    prod      = u_ext * h_ext;
    acc_sum   = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // Arithmetic shift gives floor rounding of the fixed-point product sum.
    acc_shift = acc_sum >>> FRACTION_SIZE;

    // The result fits when every bit from the target sign bit upward agrees.
    hi_bits = acc_shift[ACC_W-1:DATA_SIZE-1];
    if ((&hi_bits) || (~|hi_bits))
      y_sat = acc_shift[DATA_SIZE-1:0];
    else if (hi_bits[ACC_W-DATA_SIZE])
      y_sat = {1'b1, {(DATA_SIZE-1){1'b0}}};
    else
      y_sat = {1'b0, {(DATA_SIZE-1){1'b1}}};
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START && !size_zero) state_next = LOAD_H;
      LOAD_H:  if (h_last)              state_next = MAC;
      MAC:     if (u_last)              state_next = EMIT;
      EMIT:    state_next = row_last ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  // Counters, accumulator and registered output pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      size_l       <= '0;
      size_y       <= '0;
      idx_l        <= '0;
      idx_i        <= '0;
      acc          <= '0;
      READY        <= 1'b0;
      Y_OUT_ENABLE <= 1'b0;
      Y_OUT        <= '0;
    end else begin
      READY        <= 1'b0;
      Y_OUT_ENABLE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            size_l <= size_l_clamped;
            size_y <= SIZE_Y_IN;
            idx_l  <= '0;
            idx_i  <= '0;
            acc    <= '0;
            // Empty job: acknowledge straight away without producing data.
            if (size_zero) READY <= 1'b1;
          end
        end
        LOAD_H: begin
          if (H_IN_ENABLE) begin
            idx_l <= h_last ? '0 : idx_l + CONTROL_SIZE'(1);
            acc   <= '0;
          end
        end
        MAC: begin
          if (U_IN_ENABLE) begin
            if (u_last) begin
              // Result is registered here so the pulse lands in the EMIT cycle.
              Y_OUT        <= y_sat;
              Y_OUT_ENABLE <= 1'b1;
              READY        <= row_last;
              acc          <= '0;
              idx_l        <= '0;
            end else begin
              acc   <= acc_sum;
              idx_l <= idx_l + CONTROL_SIZE'(1);
            end
          end
        end
        EMIT: begin
          if (!row_last) idx_i <= idx_i + CONTROL_SIZE'(1);
        end
        default: ;
      endcase
    end
  end

  // Hidden vector buffer; contents persist across rows until the next load.
  always_ff @(posedge CLK) begin
    if (!RST && state == LOAD_H && H_IN_ENABLE)
      h_buf[idx_l[AW-1:0]] <= H_IN;
  end

endmodule
`default_nettype wire
